// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// Operands are cut into GROUP-bit lookahead groups. Each group is added in its own pipeline
// stage, and the carry out of a group is registered before the next stage uses it. One global
// advance signal stalls every stage at once, so the unit keeps full valid/ready backpressure.
module cla_adder_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // These guards keep the arithmetic defined long enough for the check below to fire.
    localparam int unsigned GRP_SAFE = (GROUP < 1) ? 1 : GROUP;
    localparam int unsigned NSTG     = (WIDTH / GRP_SAFE < 1) ? 1 : WIDTH / GRP_SAFE;

    if (GROUP < 1 || (WIDTH % GRP_SAFE) != 0) begin : g_bad_param
        $error("cla_adder_pipe: WIDTH must be a positive multiple of GROUP");
    end

    // Per-stage state. opa_q/opb_q carry the operands to later stages, with b already
    // conditioned for subtraction. sum_q[k] holds every sum bit produced by stages 0..k.
    logic [NSTG-1:0]  vld_q, vld_d;
    logic [NSTG-1:0]  c_q, c_d;
    logic [WIDTH-1:0] sum_q [NSTG];
    logic [WIDTH-1:0] sum_d [NSTG];
    logic [WIDTH-1:0] opa_q [NSTG];
    logic [WIDTH-1:0] opa_d [NSTG];
    logic [WIDTH-1:0] opb_q [NSTG];
    logic [WIDTH-1:0] opb_d [NSTG];
    // Carry into the MSB, which the overflow flag needs.
    logic             cm_q, cm_d;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [GROUP+1:0] grp_r;

    // Adds one group with carry lookahead. Every carry is a flat sum of products of p, g and
    // the carry-in, so there is no ripple chain. The result is packed as
    // {carry out, carry into the top bit, group sum}.
    function automatic logic [GROUP+1:0] grp_add(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             ci);
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             term;
        logic             acc;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < GROUP; i++) begin
            acc = ci;
            for (int unsigned j = 0; j <= i; j++) begin
                acc = acc & p[j];
            end
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                acc = acc | term;
            end
            c[i+1] = acc;
        end
        return {c[GROUP], c[GROUP-1], p ^ c[GROUP-1:0]};
    endfunction

    // A stall is global, so every stage moves or holds together.
    assign advance  = !vld_q[NSTG-1] || out_ready;
    assign in_ready = advance;

    // Next-state logic for every stage. Stage 0 takes its inputs from the ports, and
    // stage k takes them from the registers of stage k-1.
    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub | cin;
        vld_d = '0;
        c_d   = '0;
        cm_d  = 1'b0;
        grp_r = '0;
        for (int unsigned k = 0; k < NSTG; k++) begin
            sum_d[k] = '0;
            opa_d[k] = '0;
            opb_d[k] = '0;
        end

        grp_r                = grp_add(a[GROUP-1:0], b_eff[GROUP-1:0], c0);
        sum_d[0][GROUP-1:0]  = grp_r[GROUP-1:0];
        c_d[0]               = grp_r[GROUP+1];
        cm_d                 = grp_r[GROUP];
        vld_d[0]             = in_valid;
        opa_d[0]             = a;
        opb_d[0]             = b_eff;

        for (int unsigned k = 1; k < NSTG; k++) begin
            grp_r = grp_add(opa_q[k-1][k*GROUP +: GROUP], opb_q[k-1][k*GROUP +: GROUP],
                            c_q[k-1]);
            sum_d[k]                  = sum_q[k-1];
            sum_d[k][k*GROUP +: GROUP] = grp_r[GROUP-1:0];
            c_d[k]                    = grp_r[GROUP+1];
            // The final loop pass is the MSB group, so its value is the one that is kept.
            cm_d                      = grp_r[GROUP];
            vld_d[k]                  = vld_q[k-1];
            opa_d[k]                  = opa_q[k-1];
            opb_d[k]                  = opb_q[k-1];
        end
    end

    // Pipeline registers. Reset clears them and discards any beats still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            cm_q  <= 1'b0;
            for (int unsigned k = 0; k < NSTG; k++) begin
                sum_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            cm_q  <= cm_d;
            for (int unsigned k = 0; k < NSTG; k++) begin
                sum_q[k] <= sum_d[k];
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
            end
        end
    end

    // No stage reads the operand copy held by the last stage.
    logic unused_ops;
    assign unused_ops = ^{opa_q[NSTG-1], opb_q[NSTG-1]};

    // The flags come from the last stage's registers. zero is qualified by out_valid so the
    // idle or reset value of the output is 0.
    assign out_valid = vld_q[NSTG-1];
    assign sum       = sum_q[NSTG-1];
    assign cout      = c_q[NSTG-1];
    assign ovf       = c_q[NSTG-1] ^ cm_q;
    assign zero      = vld_q[NSTG-1] & ~|sum_q[NSTG-1];

endmodule
